// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared opcode, ALU operation, bus source and control FSM state encodings
package alu_ctrl_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [2:0] {
    ALU_PASS = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011,
    ALU_OR = 3'b100, ALU_NOT = 3'b101, ALU_INC = 3'b110, ALU_XOR = 3'b111
  } alu_op_t;
  typedef enum logic [2:0] {
    BUS_NONE = 3'b000, BUS_PC = 3'b001, BUS_IR = 3'b010, BUS_MEM = 3'b011, BUS_AC = 3'b100
  } bus_sel_t;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_EX_ADDR,
    S_EX_MEM, S_EX_ALU, S_EX_STORE, S_EX_JMP, S_HALT
  } state_t;
  function automatic logic is_illegal(input logic [3:0] op);
    return op inside {[4'hB:4'hE]};
  endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps opcode to ALU operation (PASS for non-ALU opcodes)
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_op_t    alu_op
);
  always_comb begin
    alu_op = ALU_PASS;
    case (opcode)
      OP_ADD: alu_op = ALU_ADD;
      OP_SUB: alu_op = ALU_SUB;
      OP_AND: alu_op = ALU_AND;
      OP_OR:  alu_op = ALU_OR;
      OP_XOR: alu_op = ALU_XOR;
      OP_NOT: alu_op = ALU_NOT;
      default: alu_op = ALU_PASS;
    endcase
  end
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: fetch/decode/execute FSM driving ALU op, bus select and load/strobe enables from state and IR
module alu_control_unit
  import alu_ctrl_pkg::*;
#(
  parameter int reg_width = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [reg_width-1:0] IR,
  input  logic                 z_flag,
  output logic [2:0]           ALU_Operation,
  output logic [2:0]           bus_sel,
  output logic                 ld_AC,
  output logic                 ld_IR,
  output logic                 ld_AR,
  output logic                 ld_PC,
  output logic                 inc_PC,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal
);
  state_t state_q, state_d;
  alu_op_t dec_op;
  logic [3:0] opcode;
  logic unused_ir;
  assign opcode = IR[11:8];
  assign unused_ir = ^IR;
  alu_op_decode u_dec (.opcode(opcode), .alu_op(dec_op));
  always_ff @(posedge clk) state_q <= !reset ? S_IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = start ? S_FETCH1 : S_IDLE;
      S_FETCH1:   state_d = S_FETCH2;
      S_FETCH2:   state_d = S_FETCH3;
      S_FETCH3:   state_d = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LDAC, OP_STAC, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_EX_ADDR;
          OP_NOT:         state_d = S_EX_ALU;
          OP_JMP, OP_JZ:  state_d = S_EX_JMP;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = S_FETCH1;
        endcase
      S_EX_ADDR:  state_d = opcode == OP_STAC ? S_EX_STORE : S_EX_MEM;
      S_EX_MEM:   state_d = S_EX_ALU;
      S_EX_ALU, S_EX_STORE, S_EX_JMP: state_d = S_FETCH1;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end
  always_comb begin
    bus_sel = state_q == S_FETCH1 ? BUS_PC
            : (state_q == S_EX_ADDR || state_q == S_EX_JMP) ? BUS_IR
            : (state_q == S_FETCH3 || (state_q == S_EX_ALU && opcode != OP_NOT)) ? BUS_MEM
            : state_q == S_EX_STORE ? BUS_AC : BUS_NONE;
    ALU_Operation = state_q == S_EX_ALU ? dec_op : ALU_PASS;
    ld_AC     = state_q == S_EX_ALU;
    ld_IR     = state_q == S_FETCH3;
    ld_AR     = state_q == S_FETCH1 || state_q == S_EX_ADDR;
    ld_PC     = state_q == S_EX_JMP && (opcode != OP_JZ || z_flag);
    inc_PC    = state_q == S_FETCH2;
    mem_read  = state_q == S_FETCH2 || state_q == S_EX_MEM;
    mem_write = state_q == S_EX_STORE;
    busy      = state_q != S_IDLE && state_q != S_HALT;
    halted    = state_q == S_HALT;
    illegal   = state_q == S_DECODE && is_illegal(opcode);
  end
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed self-checking bench for alu_control_unit
module tb_alu_control_unit;
  logic clk = 0, reset = 0, start = 0, z_flag = 0;
  logic [11:0] IR = 12'h000;
  logic [2:0] ALU_Operation, bus_sel;
  logic ld_AC, ld_IR, ld_AR, ld_PC, inc_PC, mem_read, mem_write, busy, halted, illegal;
  logic [15:0] obs;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  alu_control_unit #(.reg_width(12)) dut (
    .clk(clk), .reset(reset), .start(start), .IR(IR), .z_flag(z_flag),
    .ALU_Operation(ALU_Operation), .bus_sel(bus_sel), .ld_AC(ld_AC), .ld_IR(ld_IR),
    .ld_AR(ld_AR), .ld_PC(ld_PC), .inc_PC(inc_PC), .mem_read(mem_read),
    .mem_write(mem_write), .busy(busy), .halted(halted), .illegal(illegal)
  );
  assign obs = {ALU_Operation, bus_sel, ld_AC, ld_IR, ld_AR, ld_PC, inc_PC, mem_read,
                mem_write, busy, halted, illegal};
  function automatic logic [15:0] e(input logic [2:0] a, input logic [2:0] b, input logic [9:0] f);
    return {a, b, f};
  endfunction
  localparam logic [15:0] IDLE_O = 16'h0000;
  localparam logic [15:0] F1     = {3'd0, 3'd1, 10'b0010000100};
  localparam logic [15:0] F2     = {3'd0, 3'd0, 10'b0000110100};
  localparam logic [15:0] F3     = {3'd0, 3'd3, 10'b0100000100};
  localparam logic [15:0] DEC    = {3'd0, 3'd0, 10'b0000000100};
  localparam logic [15:0] DEC_IL = {3'd0, 3'd0, 10'b0000000101};
  localparam logic [15:0] EXADDR = {3'd0, 3'd2, 10'b0010000100};
  localparam logic [15:0] EXMEM  = {3'd0, 3'd0, 10'b0000010100};
  localparam logic [15:0] ALUXOR = {3'd7, 3'd3, 10'b1000000100};
  localparam logic [15:0] ALUNOT = {3'd5, 3'd0, 10'b1000000100};
  localparam logic [15:0] JMP0   = {3'd0, 3'd2, 10'b0000000100};
  localparam logic [15:0] JMP1   = {3'd0, 3'd2, 10'b0001000100};
  localparam logic [15:0] HALT_O = {3'd0, 3'd0, 10'b0000000010};
  task automatic chk(input string tag, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic sc(input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask
  initial begin
    sc("reset_c1", IDLE_O);
    sc("reset_c2", IDLE_O);
    reset = 1;
    sc("idle_hold", IDLE_O);
    IR = 12'h7C8; start = 1;
    sc("xor_f1", F1);
    start = 0;
    sc("xor_f2", F2);
    sc("xor_f3", F3);
    sc("xor_dec", DEC);
    sc("xor_exaddr", EXADDR);
    sc("xor_exmem", EXMEM);
    sc("xor_exalu_off6", ALUXOR);
    sc("xor_next_f1", F1);
    IR = 12'h800;
    sc("not_f2", F2);
    sc("not_f3", F3);
    sc("not_dec", DEC);
    sc("not_exalu_off4", ALUNOT);
    sc("not_next_f1", F1);
    IR = 12'hA10; z_flag = 0;
    sc("jz0_f2", F2);
    sc("jz0_f3", F3);
    sc("jz0_dec", DEC);
    sc("jz0_exjmp", JMP0);
    sc("jz0_next_f1", F1);
    z_flag = 1;
    sc("jz1_f2", F2);
    sc("jz1_f3", F3);
    sc("jz1_dec", DEC);
    sc("jz1_exjmp", JMP1);
    sc("jz1_next_f1", F1);
    IR = 12'hC00;
    sc("ill_f2", F2);
    sc("ill_f3", F3);
    sc("ill_dec", DEC_IL);
    sc("ill_next_f1", F1);
    IR = 12'hF00;
    sc("halt_f2", F2);
    sc("halt_f3", F3);
    sc("halt_dec", DEC);
    sc("halt_enter", HALT_O);
    start = 1;
    for (int i = 0; i < 20; i++) sc("halt_hold", HALT_O);
    reset = 0;
    sc("halt_reset", IDLE_O);
    sc("start_in_reset", IDLE_O);
    reset = 1;
    sc("start_after_reset", F1);
    start = 0; IR = 12'h3FF;
    sc("add_f2", F2);
    sc("add_f3", F3);
    sc("add_dec", DEC);
    sc("add_exaddr", EXADDR);
    sc("add_exmem", EXMEM);
    reset = 0;
    sc("mid_reset_idle", IDLE_O);
    reset = 1;
    sc("mid_reset_hold", IDLE_O);
    start = 1;
    sc("restart_f1", F1);
    start = 0;
    sc("restart_f2", F2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
